retire_unit: RTL and testbench

RETIRE_UNIT -- requirements
Module: retire_unit

---
 rtl/retire_unit.sv | 158 +++++++++++++++
 tb/tb_retire_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// In-order reorder/retire buffer: dual allocate, dual complete, up to two retires per cycle.
// Optional synchronous flush port is compiled in when ROB_FLUSH_EN is defined.
module retire_unit #(
  parameter int ROB_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         alloc_en_A,
  input  logic                         alloc_en_B,
  input  logic                         alloc_wb_A,
  input  logic                         alloc_wb_B,
  input  logic [4:0]                   alloc_rd_A,
  input  logic [4:0]                   alloc_rd_B,
  output logic [$clog2(ROB_DEPTH)-1:0] alloc_tag_A,
  output logic [$clog2(ROB_DEPTH)-1:0] alloc_tag_B,
  output logic                         alloc_stall,
  input  logic                         cmpl_en_A,
  input  logic                         cmpl_en_B,
  input  logic [$clog2(ROB_DEPTH)-1:0] cmpl_tag_A,
  input  logic [$clog2(ROB_DEPTH)-1:0] cmpl_tag_B,
  output logic                         updateEnA,
  output logic                         updateEnB,
  output logic [4:0]                   updateAddrA,
  output logic [4:0]                   updateAddrB,
  output logic [$clog2(ROB_DEPTH):0]   rob_count
);

  localparam int TW = $clog2(ROB_DEPTH);
  typedef logic [TW-1:0] tag_t;
  typedef logic [TW:0]   cnt_t;

  tag_t                 head_reg, head_next, head_plus1;
  tag_t                 tail_reg, tail_next;
  cnt_t                 count_reg, count_next, free_cnt;
  logic [ROB_DEPTH-1:0] valid_reg, done_reg, wb_reg;
  logic [4:0]           rd_reg [ROB_DEPTH];

  logic                 upd_en_a_reg, upd_en_b_reg;
  logic [4:0]           upd_addr_a_reg, upd_addr_b_reg;

  logic [1:0]           req_cnt, grant_cnt, retire_cnt;
  logic                 grant_a, grant_b, retire_a, retire_b;
  logic                 flush_act;

  logic [ROB_DEPTH-1:0] alloc_a_hit, alloc_b_hit, retire_hit, cmpl_hit;

`ifdef ROB_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Free space comes from registered occupancy only; a retire this cycle
  // does not make room for an allocation in the same cycle.
  always_comb begin
    req_cnt     = {1'b0, alloc_en_A} + {1'b0, alloc_en_B};
    free_cnt    = cnt_t'(ROB_DEPTH) - count_reg;
    alloc_stall = (cnt_t'(req_cnt) > free_cnt) || flush_act;
    grant_a     = alloc_en_A && !alloc_stall;
    grant_b     = alloc_en_B && !alloc_stall;
    alloc_tag_A = tail_reg;
    alloc_tag_B = alloc_en_A ? tail_reg + tag_t'(1) : tail_reg;
  end

  // The second retire slot only fires behind a retiring head.
  always_comb begin
    head_plus1 = head_reg + tag_t'(1);
    retire_a   = valid_reg[head_reg] && done_reg[head_reg];
    retire_b   = retire_a && valid_reg[head_plus1] && done_reg[head_plus1];
    grant_cnt  = {1'b0, grant_a} + {1'b0, grant_b};
    retire_cnt = {1'b0, retire_a} + {1'b0, retire_b};
    tail_next  = tail_reg + tag_t'(grant_cnt);
    head_next  = head_reg + tag_t'(retire_cnt);
    count_next = count_reg + cnt_t'(grant_cnt) - cnt_t'(retire_cnt);
  end

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      assign alloc_a_hit[gi] = grant_a && (alloc_tag_A == tag_t'(gi));
      assign alloc_b_hit[gi] = grant_b && (alloc_tag_B == tag_t'(gi));
      assign retire_hit[gi]  = (retire_a && (head_reg == tag_t'(gi))) ||
                               (retire_b && (head_plus1 == tag_t'(gi)));
      // Completions to empty slots are dropped; duplicate tags collapse to one set.
      assign cmpl_hit[gi]    = valid_reg[gi] &&
                               ((cmpl_en_A && (cmpl_tag_A == tag_t'(gi))) ||
                                (cmpl_en_B && (cmpl_tag_B == tag_t'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      done_reg       <= '0;
      wb_reg         <= '0;
      upd_en_a_reg   <= 1'b0;
      upd_en_b_reg   <= 1'b0;
      upd_addr_a_reg <= '0;
      upd_addr_b_reg <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_reg[i] <= '0;
      end
    end else if (flush_act) begin
      // Flush empties the buffer but leaves the last update addresses visible.
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      valid_reg    <= '0;
      done_reg     <= '0;
      upd_en_a_reg <= 1'b0;
      upd_en_b_reg <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;

      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (alloc_a_hit[i] || alloc_b_hit[i]) begin
          valid_reg[i] <= 1'b1;
          done_reg[i]  <= 1'b0;
          wb_reg[i]    <= alloc_a_hit[i] ? alloc_wb_A : alloc_wb_B;
          rd_reg[i]    <= alloc_a_hit[i] ? alloc_rd_A : alloc_rd_B;
        end else if (retire_hit[i]) begin
          valid_reg[i] <= 1'b0;
          done_reg[i]  <= 1'b0;
        end else if (cmpl_hit[i]) begin
          done_reg[i]  <= 1'b1;
        end
      end

      if (retire_a) begin
        upd_en_a_reg   <= wb_reg[head_reg];
        upd_addr_a_reg <= rd_reg[head_reg];
      end else begin
        upd_en_a_reg   <= 1'b0;
      end

      if (retire_b) begin
        upd_en_b_reg   <= wb_reg[head_plus1];
        upd_addr_b_reg <= rd_reg[head_plus1];
      end else begin
        upd_en_b_reg   <= 1'b0;
      end
    end
  end

  assign updateEnA   = upd_en_a_reg;
  assign updateEnB   = upd_en_b_reg;
  assign updateAddrA = upd_addr_a_reg;
  assign updateAddrB = upd_addr_b_reg;
  assign rob_count   = count_reg;

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit (default build, ROB_DEPTH=8): allocation, completion,
// dual retire, full/stall, wb=0 retire, stray completion and mid-stream reset.
module tb_retire_unit;

  logic       clk;
  logic       rst;
  logic       alloc_en_A, alloc_en_B, alloc_wb_A, alloc_wb_B;
  logic [4:0] alloc_rd_A, alloc_rd_B;
  logic [2:0] alloc_tag_A, alloc_tag_B;
  logic       alloc_stall;
  logic       cmpl_en_A, cmpl_en_B;
  logic [2:0] cmpl_tag_A, cmpl_tag_B;
  logic       updateEnA, updateEnB;
  logic [4:0] updateAddrA, updateAddrB;
  logic [3:0] rob_count;

  int checks = 0;
  int errors = 0;

  retire_unit #(.ROB_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_en_A(alloc_en_A), .alloc_en_B(alloc_en_B),
    .alloc_wb_A(alloc_wb_A), .alloc_wb_B(alloc_wb_B),
    .alloc_rd_A(alloc_rd_A), .alloc_rd_B(alloc_rd_B),
    .alloc_tag_A(alloc_tag_A), .alloc_tag_B(alloc_tag_B),
    .alloc_stall(alloc_stall),
    .cmpl_en_A(cmpl_en_A), .cmpl_en_B(cmpl_en_B),
    .cmpl_tag_A(cmpl_tag_A), .cmpl_tag_B(cmpl_tag_B),
    .updateEnA(updateEnA), .updateEnB(updateEnB),
    .updateAddrA(updateAddrA), .updateAddrB(updateAddrB),
    .rob_count(rob_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_alloc();
    alloc_en_A = 1'b0; alloc_en_B = 1'b0;
  endtask

  task automatic clear_cmpl();
    cmpl_en_A = 1'b0; cmpl_en_B = 1'b0;
  endtask

  task automatic set_alloc(input logic ea, input logic [4:0] ra, input logic wa,
                           input logic eb, input logic [4:0] rb, input logic wb);
    alloc_en_A = ea; alloc_rd_A = ra; alloc_wb_A = wa;
    alloc_en_B = eb; alloc_rd_B = rb; alloc_wb_B = wb;
  endtask

  task automatic set_cmpl(input logic ea, input logic [2:0] ta,
                          input logic eb, input logic [2:0] tb);
    cmpl_en_A = ea; cmpl_tag_A = ta;
    cmpl_en_B = eb; cmpl_tag_B = tb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_alloc(0, 0, 0, 0, 0, 0);
    set_cmpl(0, 0, 0, 0);
    #1;
    do_reset();
    #1;
    check("reset count", rob_count, 0);
    check("reset stall", alloc_stall, 0);
    check("reset tagA", alloc_tag_A, 0);
    check("reset tagB", alloc_tag_B, 0);
    check("reset updEnA", updateEnA, 0);
    check("reset updAddrA", updateAddrA, 0);

    // Dual allocation then out-of-order completion, paired retire
    set_alloc(1, 5, 1, 1, 6, 1);
    #1;
    check("dual tagA", alloc_tag_A, 0);
    check("dual tagB", alloc_tag_B, 1);
    check("dual stall", alloc_stall, 0);
    cyc();
    clear_alloc();
    check("dual count", rob_count, 2);
    set_cmpl(1, 1, 0, 0);
    cyc();
    set_cmpl(1, 0, 0, 0);
    cyc();
    clear_cmpl();
    check("no lone head+1 updEnA", updateEnA, 0);
    check("no lone head+1 count", rob_count, 2);
    cyc();
    check("pair updEnA", updateEnA, 1);
    check("pair updAddrA", updateAddrA, 5);
    check("pair updEnB", updateEnB, 1);
    check("pair updAddrB", updateAddrB, 6);
    check("pair count", rob_count, 0);
    cyc();
    check("pulse end updEnA", updateEnA, 0);
    check("pulse end updEnB", updateEnB, 0);
    check("hold updAddrA", updateAddrA, 5);

    // Fill to full, stall behaviour and wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1, 5'(8 + 2 * i), 1, 1, 5'(9 + 2 * i), 1);
      #1;
      check("fill tagA", alloc_tag_A, 2 * i);
      check("fill tagB", alloc_tag_B, 2 * i + 1);
      cyc();
    end
    clear_alloc();
    check("full count", rob_count, 8);
    set_alloc(1, 1, 1, 1, 2, 1);
    #1;
    check("full stall", alloc_stall, 1);
    cyc();
    clear_alloc();
    check("full count held", rob_count, 8);
    set_cmpl(1, 0, 0, 0);
    cyc();
    clear_cmpl();
    cyc();
    check("single retire count", rob_count, 7);
    check("single retire updEnA", updateEnA, 1);
    check("single retire updAddrA", updateAddrA, 8);
    check("single retire updEnB", updateEnB, 0);
    set_alloc(1, 1, 1, 1, 2, 1);
    #1;
    check("one free dual stall", alloc_stall, 1);
    cyc();
    clear_alloc();
    check("no partial alloc count", rob_count, 7);
    set_alloc(1, 20, 0, 0, 0, 0);
    #1;
    check("one free A stall", alloc_stall, 0);
    check("wrap tagA", alloc_tag_A, 0);
    cyc();
    clear_alloc();
    check("refill count", rob_count, 8);

    // Retire with wb=0
    do_reset();
    set_alloc(1, 9, 0, 0, 0, 0);
    #1;
    check("wb0 tagA", alloc_tag_A, 0);
    cyc();
    clear_alloc();
    set_cmpl(1, 0, 0, 0);
    cyc();
    clear_cmpl();
    cyc();
    check("wb0 updEnA", updateEnA, 0);
    check("wb0 updAddrA", updateAddrA, 9);
    check("wb0 count", rob_count, 0);

    // Completion to an invalid entry is dropped
    set_cmpl(1, 3, 0, 0);
    cyc();
    clear_cmpl();
    set_alloc(1, 1, 1, 1, 2, 1);
    #1;
    check("stray tagA", alloc_tag_A, 1);
    check("stray tagB", alloc_tag_B, 2);
    cyc();
    set_alloc(1, 7, 1, 0, 0, 0);
    #1;
    check("stray tag3", alloc_tag_A, 3);
    cyc();
    clear_alloc();
    check("stray count", rob_count, 3);
    set_cmpl(1, 1, 1, 2);
    cyc();
    clear_cmpl();
    set_alloc(1, 4, 1, 0, 0, 0);
    cyc();
    clear_alloc();
    check("alloc+retire updEnA", updateEnA, 1);
    check("alloc+retire updAddrA", updateAddrA, 1);
    check("alloc+retire updEnB", updateEnB, 1);
    check("alloc+retire updAddrB", updateAddrB, 2);
    check("alloc+retire count", rob_count, 2);
    cyc();
    check("entry3 not done updEnA", updateEnA, 0);
    check("entry3 not done count", rob_count, 2);
    set_cmpl(1, 3, 1, 3);
    cyc();
    clear_cmpl();
    cyc();
    check("dup cmpl updEnA", updateEnA, 1);
    check("dup cmpl updAddrA", updateAddrA, 7);
    check("dup cmpl updEnB", updateEnB, 0);
    check("dup cmpl count", rob_count, 1);

    // Reset asserted mid-stream with activity pending
    set_alloc(1, 11, 1, 1, 12, 1);
    cyc();
    set_alloc(1, 13, 1, 0, 0, 0);
    cyc();
    clear_alloc();
    check("mid count", rob_count, 4);
    set_cmpl(1, 4, 0, 0);
    cyc();
    rst = 1'b1;
    set_alloc(1, 14, 1, 0, 0, 0);
    set_cmpl(1, 5, 0, 0);
    cyc();
    rst = 1'b0;
    clear_alloc();
    clear_cmpl();
    #1;
    check("midrst count", rob_count, 0);
    check("midrst updEnA", updateEnA, 0);
    check("midrst updEnB", updateEnB, 0);
    check("midrst updAddrA", updateAddrA, 0);
    check("midrst updAddrB", updateAddrB, 0);
    check("midrst stall", alloc_stall, 0);
    check("midrst tagA", alloc_tag_A, 0);
    check("midrst tagB", alloc_tag_B, 0);
    set_alloc(1, 15, 1, 0, 0, 0);
    #1;
    check("post rst tagA", alloc_tag_A, 0);
    cyc();
    clear_alloc();
    check("post rst count", rob_count, 1);
    cyc();
    check("post rst no retire", updateEnA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
